// File: rtl/inst_tx2pcm_ser.sv
// inst_tx2pcm_ser: buffers wide instruction frames and serializes each one,
// most significant word first, onto a valid/ready word stream with sof/eof.
module inst_tx2pcm_ser #(
    parameter int U_DLY   = 1,
    parameter int FRAME_W = 512,
    parameter int WORD_W  = 8,
    parameter int DEPTH   = 2
) (
    input  logic               clk_sys,
    input  logic               rst,
    input  logic [15:0]        cfg_ins_length,
    input  logic [FRAME_W-1:0] pcm_inst_data,
    input  logic               pcm_inst_data_valid,
    output logic               pcm_inst_full,
    output logic               pcm_inst_ovf,
    output logic [WORD_W-1:0]  pcm_tx_data,
    output logic               pcm_tx_data_valid,
    input  logic               pcm_tx_data_ready,
    output logic               pcm_tx_sof,
    output logic               pcm_tx_eof,
    output logic               pcm_tx_busy
);

    localparam int unsigned N_WORDS = FRAME_W / WORD_W;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LVL_W   = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W   = $clog2(N_WORDS + 1);

    // Reject parameter sets the pointer arithmetic and word slicing cannot support
    if ((FRAME_W % WORD_W) != 0 || FRAME_W <= WORD_W || DEPTH < 2 ||
        (DEPTH & (DEPTH - 1)) != 0 || U_DLY < 0) begin : g_param_check
        $error("inst_tx2pcm_ser: illegal parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t               state_q;
    logic [FRAME_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [LVL_W-1:0]     level_q;
    logic [LVL_W-1:0]     level_d;
    logic                 full_q;
    logic                 full_d;
    logic                 ovf_q;
    logic [FRAME_W-1:0]   shift_q;
    logic [CNT_W-1:0]     len_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 valid_q;
    logic                 sof_q;
    logic                 eof_q;
    logic                 busy_q;
    logic                 push_c;
    logic                 pop_c;
    logic [CNT_W-1:0]     eff_len_c;

    // Buffer push/pop decisions and next fill level
    always_comb begin
        push_c  = pcm_inst_data_valid && !full_q;
        pop_c   = (state_q == ST_LOAD);
        level_d = level_q;
        if (push_c && !pop_c) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push_c && pop_c) begin
            level_d = level_q - LVL_W'(1);
        end
        full_d = (level_d == LVL_W'(DEPTH));
    end

    // Out-of-range lengths (zero or larger than a frame) fall back to a full frame
    always_comb begin
        eff_len_c = CNT_W'(N_WORDS);
        if (cfg_ins_length != 16'd0 && 32'(cfg_ins_length) <= N_WORDS) begin
            eff_len_c = CNT_W'(cfg_ins_length);
        end
    end

    // Frame storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk_sys) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= pcm_inst_data;
        end
    end

    // Buffer pointers, level, full flag and overflow pulse
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
            full_q  <= full_d;
            // A strobe while full is dropped even if a pop frees a slot on this edge
            ovf_q   <= pcm_inst_data_valid && full_q;
        end
    end

    // Serializer FSM with registered stream outputs
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (level_q != '0) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    shift_q <= mem_q[rd_ptr_q];
                    len_q   <= eff_len_c;
                    cnt_q   <= '0;
                    valid_q <= 1'b1;
                    sof_q   <= 1'b1;
                    eof_q   <= (eff_len_c == CNT_W'(1));
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    if (pcm_tx_data_ready) begin
                        shift_q <= shift_q << WORD_W;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        sof_q   <= 1'b0;
                        if (eof_q) begin
                            valid_q <= 1'b0;
                            eof_q   <= 1'b0;
                            if (level_q != '0) begin
                                state_q <= ST_LOAD;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            // Next word is the last one when cnt+1 == len-1
                            eof_q <= ((cnt_q + CNT_W'(2)) == len_q);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    sof_q   <= 1'b0;
                    eof_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pcm_tx_data       = shift_q[FRAME_W-1 -: WORD_W];
    assign pcm_tx_data_valid = valid_q;
    assign pcm_tx_sof        = sof_q;
    assign pcm_tx_eof        = eof_q;
    assign pcm_tx_busy       = busy_q;
    assign pcm_inst_full     = full_q;
    assign pcm_inst_ovf      = ovf_q;

endmodule

// File: tb/tb_inst_tx2pcm_ser.sv
// Scoreboard bench for inst_tx2pcm_ser with directed frames (default parameters).
module tb_inst_tx2pcm_ser;

    localparam int FRAME_W = 512;
    localparam int WORD_W  = 8;
    localparam int DEPTH   = 2;
    localparam int N_WORDS = FRAME_W / WORD_W;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [15:0]        cfg_ins_length = 16'd64;
    logic [FRAME_W-1:0] pcm_inst_data = '0;
    logic               pcm_inst_data_valid = 1'b0;
    logic               pcm_inst_full;
    logic               pcm_inst_ovf;
    logic [WORD_W-1:0]  pcm_tx_data;
    logic               pcm_tx_data_valid;
    logic               pcm_tx_data_ready = 1'b1;
    logic               pcm_tx_sof;
    logic               pcm_tx_eof;
    logic               pcm_tx_busy;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   ovf_cnt = 0;
    bit   gap_arm = 1'b0;
    int   gap     = 0;

    inst_tx2pcm_ser #(
        .U_DLY  (1),
        .FRAME_W(FRAME_W),
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_sys            (clk),
        .rst                (rst),
        .cfg_ins_length     (cfg_ins_length),
        .pcm_inst_data      (pcm_inst_data),
        .pcm_inst_data_valid(pcm_inst_data_valid),
        .pcm_inst_full      (pcm_inst_full),
        .pcm_inst_ovf       (pcm_inst_ovf),
        .pcm_tx_data        (pcm_tx_data),
        .pcm_tx_data_valid  (pcm_tx_data_valid),
        .pcm_tx_data_ready  (pcm_tx_data_ready),
        .pcm_tx_sof         (pcm_tx_sof),
        .pcm_tx_eof         (pcm_tx_eof),
        .pcm_tx_busy        (pcm_tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FRAME_W-1:0] mk_frame(input logic [7:0] base);
        logic [FRAME_W-1:0] f;
        f = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            f[FRAME_W-1-8*k -: 8] = 8'(base + 8'(k));
        end
        return f;
    endfunction

    function automatic int eff_len(input logic [15:0] cfg);
        if (cfg >= 16'd1 && cfg <= 16'(N_WORDS)) return int'(cfg);
        return N_WORDS;
    endfunction

    task automatic push_exp(input logic [7:0] base, input int len);
        exp_t e;
        for (int k = 0; k < len; k++) begin
            e.data = 8'(base + 8'(k));
            e.sof  = (k == 0);
            e.eof  = (k == len - 1);
            sb_q.push_back(e);
        end
    endtask

    // One-cycle frame strobe; expected words queued only for accepted frames
    task automatic send_frame(input logic [7:0] base, input bit accept);
        @(posedge clk); #1;
        pcm_inst_data       = mk_frame(base);
        pcm_inst_data_valid = 1'b1;
        if (accept) push_exp(base, eff_len(cfg_ins_length));
        @(posedge clk); #1;
        pcm_inst_data_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pcm_tx_data_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 64'(ok), 64'd1);
    endtask

    task automatic wait_drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !pcm_tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 64'(ok), 64'd1);
    endtask

    // Monitor: every presented word must match the scoreboard head; pop on handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            gap_arm = 1'b0;
        end else begin
            if (pcm_inst_ovf) ovf_cnt++;
            if (pcm_tx_data_valid) begin
                if (gap_arm) begin
                    check("load_gap", 64'(gap), 64'd1);
                    gap_arm = 1'b0;
                end
                if (sb_q.size() == 0) begin
                    check("unexpected_word", {54'd0, pcm_tx_data, pcm_tx_sof, pcm_tx_eof}, 64'h3ff);
                end else begin
                    e = sb_q[0];
                    check("word", {54'd0, pcm_tx_data, pcm_tx_sof, pcm_tx_eof}, {54'd0, e});
                    if (pcm_tx_data_ready) begin
                        void'(sb_q.pop_front());
                        if (e.eof && sb_q.size() != 0) begin
                            gap_arm = 1'b1;
                            gap     = 0;
                        end
                    end
                end
            end else if (gap_arm) begin
                gap++;
            end
        end
    end

    initial begin
        logic [3:0] rdy_pat;
        int         nvalid;
        rdy_pat = 4'b1001;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_hold_outputs", {53'd0, pcm_tx_data, pcm_tx_data_valid, pcm_tx_sof, pcm_tx_eof},
              64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_flags", {60'd0, pcm_tx_busy, pcm_inst_full, pcm_inst_ovf, pcm_tx_data_valid},
              64'd0);

        // Full 64-byte frame 0x01..0x40 with latency check
        cfg_ins_length = 16'd64;
        send_frame(8'h01, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("latency_cycle1_low", 64'(pcm_tx_data_valid), 64'd0);
        @(negedge clk);
        check("latency_cycle2_high", 64'(pcm_tx_data_valid), 64'd1);
        wait_drain("drain_full_frame");

        // Length 3, 0 (full), 100 (full), 1 (sof and eof together)
        cfg_ins_length = 16'd3;
        send_frame(8'h50, 1'b1);
        wait_drain("drain_len3");
        cfg_ins_length = 16'd0;
        send_frame(8'h80, 1'b1);
        wait_drain("drain_len0");
        cfg_ins_length = 16'd100;
        send_frame(8'hC0, 1'b1);
        wait_drain("drain_len100");
        cfg_ins_length = 16'd1;
        send_frame(8'h99, 1'b1);
        wait_drain("drain_len1");

        // Backpressure pattern 1-0-0-1 during SEND
        cfg_ins_length = 16'd5;
        send_frame(8'h70, 1'b1);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            pcm_tx_data_ready = rdy_pat[i % 4];
            if (sb_q.size() == 0 && !pcm_tx_busy) break;
        end
        pcm_tx_data_ready = 1'b1;
        wait_drain("drain_stall");

        // Overflow: three back-to-back strobes while a frame is being sent
        cfg_ins_length = 16'd64;
        send_frame(8'h10, 1'b1);
        wait_valid("ovf_first_valid");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            pcm_inst_data       = mk_frame(8'h60 + 8'(i * 64));
            pcm_inst_data_valid = 1'b1;
            if (i < 2) push_exp(8'h60 + 8'(i * 64), 64);
        end
        @(posedge clk); #1;
        pcm_inst_data_valid = 1'b0;
        @(negedge clk);
        check("ovf_pulse", {62'd0, pcm_inst_ovf, pcm_inst_full}, 64'd3);
        @(negedge clk);
        check("ovf_clear_full_held", {62'd0, pcm_inst_ovf, pcm_inst_full}, 64'd1);
        wait_drain("drain_ovf");
        check("ovf_pulse_count", 64'(ovf_cnt), 64'd1);

        // Reset at word 10 with one frame buffered
        send_frame(8'h05, 1'b1);
        wait_valid("rst_test_valid");
        send_frame(8'h33, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("rst_outputs_immediate",
              {49'd0, pcm_tx_data, pcm_tx_data_valid, pcm_tx_sof, pcm_tx_eof, pcm_tx_busy,
               pcm_inst_full, pcm_inst_ovf},
              64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pcm_tx_data_valid || pcm_tx_busy) nvalid++;
        end
        check("quiet_after_rst", 64'(nvalid), 64'd0);
        cfg_ins_length = 16'd2;
        send_frame(8'h20, 1'b1);
        wait_drain("drain_after_rst");

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
